// File: rtl/packetizer.sv
// packetizer -- transmit-side framer for the mixed BPSK/QPSK link.
//
// Each frame is a BPSK training run taken from a 7-bit LFSR, then a 64-symbol
// BPSK header {MCS, length, signature, 32 zeros}, then a BPSK or QPSK payload
// taken from an AXI-Stream byte source. One symbol is produced on every clk
// edge where clk_enable is high. A single invalid GAP symbol follows each frame.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   clk_enable      symbol strobe; the FSM and symbol outputs advance only on enabled edges
//   start           frame request, sampled in IDLE on an enabled edge
//   cfg_mcs/len/sig frame configuration, latched at start (cfg_mcs[5]=1 -> BPSK payload)
//   s_tdata/s_tvalid/s_tready/s_tlast  payload AXIS sink (s_tlast is ignored)
//   sym_valid, sym_bpsk, sym_qpsk, is_bpsk, sym_last  registered symbol stream
//   busy            FSM is not IDLE
//   underrun        one-cycle pulse when a payload word was not available in time
module packetizer #(
  parameter int BYTES   = 1,
  parameter int TRN_LEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_enable,
  input  logic                 start,
  input  logic [7:0]           cfg_mcs,
  input  logic [15:0]          cfg_len,
  input  logic [7:0]           cfg_sig,
  input  logic [BYTES*8-1:0]   s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tlast,
  output logic                 sym_valid,
  output logic                 sym_bpsk,
  output logic [1:0]           sym_qpsk,
  output logic                 is_bpsk,
  output logic                 sym_last,
  output logic                 busy,
  output logic                 underrun
);
  localparam int W  = BYTES * 8;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {IDLE, TRN, HDR, PLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [6:0]    lfsr_q, lfsr_d;
  logic [7:0]    mcs_q, mcs_d, sig_q, sig_d;
  logic [15:0]   len_q, len_d, nsym_q, nsym_d;
  logic [16:0]   need_q, need_d, fetch_q, fetch_d;
  logic [W-1:0]  hold_q, hold_d, shift_q, shift_d;
  logic          hold_full_q, hold_full_d;
  logic [CW-1:0] shift_cnt_q, shift_cnt_d;
  logic          sym_valid_q, sym_valid_d, sym_bpsk_q, sym_bpsk_d;
  logic [1:0]    sym_qpsk_q, sym_qpsk_d;
  logic          is_bpsk_q, is_bpsk_d, sym_last_q, sym_last_d, underrun_q, underrun_d;

  logic          xfer, skip;
  logic [15:0]   nsym_new;
  logic [16:0]   bits_new;
  logic [63:0]   hdr;
  logic [W-1:0]  word;
  logic [CW-1:0] kbits;
  logic          unused_tlast;

  assign unused_tlast = s_tlast;

  // Symbol count and the number of words the payload will consume.
  assign nsym_new = cfg_mcs[5] ? cfg_len : {1'b0, cfg_len[15:1]};
  assign bits_new = cfg_mcs[5] ? {1'b0, nsym_new} : {nsym_new, 1'b0};
  assign hdr      = {mcs_q, len_q, sig_q, 32'h0};
  assign kbits    = mcs_q[5] ? CW'(1) : CW'(2);

  assign s_tready = ((state_q == HDR) || (state_q == PLD)) && !hold_full_q && (fetch_q < need_q);
  assign xfer     = s_tvalid && s_tready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    mcs_d       = mcs_q;
    sig_d       = sig_q;
    len_d       = len_q;
    nsym_d      = nsym_q;
    need_d      = need_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    shift_cnt_d = shift_cnt_q;
    sym_valid_d = sym_valid_q;
    sym_bpsk_d  = sym_bpsk_q;
    sym_qpsk_d  = sym_qpsk_q;
    is_bpsk_d   = is_bpsk_q;
    sym_last_d  = sym_last_q;
    underrun_d  = 1'b0;
    skip        = 1'b0;
    word        = shift_q;

    // AXIS side runs every clk, independent of the symbol strobe.
    if (xfer) begin
      hold_d      = s_tdata;
      hold_full_d = 1'b1;
    end

    if (clk_enable) begin
      case (state_q)
        IDLE: begin
          sym_valid_d = 1'b0;
          sym_bpsk_d  = 1'b0;
          sym_qpsk_d  = 2'b00;
          sym_last_d  = 1'b0;
          is_bpsk_d   = 1'b1;
          if (start) begin
            mcs_d   = cfg_mcs;
            len_d   = cfg_len;
            sig_d   = cfg_sig;
            nsym_d  = nsym_new;
            need_d  = (bits_new + 17'(W - 1)) / 17'(W);
            cnt_d   = 16'd0;
            lfsr_d  = 7'h7F;
            state_d = TRN;
          end
        end
        TRN: begin
          sym_valid_d = 1'b1;
          sym_bpsk_d  = lfsr_q[6];
          sym_qpsk_d  = {lfsr_q[6], lfsr_q[6]};
          sym_last_d  = 1'b0;
          is_bpsk_d   = 1'b1;
          lfsr_d      = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
          if (cnt_q == 16'(TRN_LEN - 1)) begin
            cnt_d   = 16'd0;
            state_d = HDR;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        HDR: begin
          sym_valid_d = 1'b1;
          sym_bpsk_d  = hdr[6'd63 - cnt_q[5:0]];
          sym_qpsk_d  = {hdr[6'd63 - cnt_q[5:0]], hdr[6'd63 - cnt_q[5:0]]};
          is_bpsk_d   = 1'b1;
          sym_last_d  = (cnt_q == 16'd63) && (nsym_q == 16'd0);
          if (cnt_q == 16'd63) begin
            cnt_d   = 16'd0;
            state_d = (nsym_q != 16'd0) ? PLD : GAP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        PLD: begin
          is_bpsk_d = mcs_q[5];
          if (shift_cnt_q == '0) begin
            // Shift register exhausted: take the next word, or skip the whole
            // word slot with zeros so the frame length stays fixed.
            if (hold_full_q) begin
              word        = hold_q;
              hold_full_d = 1'b0;
            end else begin
              word       = '0;
              skip       = 1'b1;
              underrun_d = 1'b1;
            end
            shift_cnt_d = CW'(W) - kbits;
          end else begin
            word        = shift_q;
            shift_cnt_d = shift_cnt_q - kbits;
          end
          shift_d     = mcs_q[5] ? {word[W-2:0], 1'b0} : {word[W-3:0], 2'b00};
          sym_valid_d = 1'b1;
          sym_bpsk_d  = word[W-1];
          sym_qpsk_d  = mcs_q[5] ? {word[W-1], word[W-1]} : word[W-1:W-2];
          if (cnt_q == nsym_q - 16'd1) begin
            sym_last_d = 1'b1;
            cnt_d      = 16'd0;
            state_d    = GAP;
          end else begin
            sym_last_d = 1'b0;
            cnt_d      = cnt_q + 16'd1;
          end
        end
        GAP: begin
          sym_valid_d = 1'b0;
          sym_bpsk_d  = 1'b0;
          sym_qpsk_d  = 2'b00;
          sym_last_d  = 1'b0;
          is_bpsk_d   = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // A skipped slot counts as fetched so late data cannot overfill the frame.
    fetch_d = fetch_q + {16'd0, xfer} + {16'd0, skip};

    if (state_q == IDLE) begin
      hold_full_d = 1'b0;
      shift_cnt_d = '0;
      fetch_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lfsr_q      <= 7'h7F;
      mcs_q       <= '0;
      sig_q       <= '0;
      len_q       <= '0;
      nsym_q      <= '0;
      need_q      <= '0;
      fetch_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      shift_cnt_q <= '0;
      sym_valid_q <= 1'b0;
      sym_bpsk_q  <= 1'b0;
      sym_qpsk_q  <= 2'b00;
      is_bpsk_q   <= 1'b1;
      sym_last_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      mcs_q       <= mcs_d;
      sig_q       <= sig_d;
      len_q       <= len_d;
      nsym_q      <= nsym_d;
      need_q      <= need_d;
      fetch_q     <= fetch_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      shift_cnt_q <= shift_cnt_d;
      sym_valid_q <= sym_valid_d;
      sym_bpsk_q  <= sym_bpsk_d;
      sym_qpsk_q  <= sym_qpsk_d;
      is_bpsk_q   <= is_bpsk_d;
      sym_last_q  <= sym_last_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_bpsk  = sym_bpsk_q;
  assign sym_qpsk  = sym_qpsk_q;
  assign is_bpsk   = is_bpsk_q;
  assign sym_last  = sym_last_q;
  assign underrun  = underrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_packetizer.sv
module tb_packetizer;
  localparam int TRN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_enable = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_mcs = '0;
  logic [15:0] cfg_len = '0;
  logic [7:0]  cfg_sig = '0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b1;
  logic        sym_valid, sym_bpsk, is_bpsk, sym_last, busy, underrun;
  logic [1:0]  sym_qpsk;

  packetizer #(.BYTES(1), .TRN_LEN(TRN)) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .start(start),
    .cfg_mcs(cfg_mcs), .cfg_len(cfg_len), .cfg_sig(cfg_sig),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .sym_valid(sym_valid), .sym_bpsk(sym_bpsk), .sym_qpsk(sym_qpsk), .is_bpsk(is_bpsk),
    .sym_last(sym_last), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] q;
    logic       isb;
    logic       last;
  } sym_t;

  sym_t       exp_q[$];
  logic [7:0] src_q[$];
  int total = 0, bad = 0;
  int acc_cnt = 0, urun_cnt = 0, rdy_seen = 0, gaps_checked = 0, inv_run = 0, cyc = 0;
  bit src_en = 0, div4 = 0, gap_check = 0, last_seen = 0;
  logic [5:0] prev = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Strobe and AXIS source are driven away from the active edge.
  always @(negedge clk) begin
    cyc++;
    clk_enable = div4 ? (cyc % 4 == 0) : 1'b1;
    s_tvalid   = src_en && (src_q.size() > 0);
    s_tdata    = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  // Monitor: pops expected symbols whenever the DUT presents one.
  always @(posedge clk) begin
    bit en_s, rst_s;
    sym_t e;
    en_s  = clk_enable;
    rst_s = rst;
    if (!rst_s && s_tvalid && s_tready) begin
      acc_cnt++;
      void'(src_q.pop_front());
    end
    if (!rst_s && s_tready) rdy_seen++;
    #1;
    if (!rst_s) begin
      if (en_s) begin
        if (sym_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_symbol: got valid symbol q=%b expected none", sym_qpsk);
          end else begin
            e = exp_q.pop_front();
            chk("sym_qpsk", {30'd0, sym_qpsk}, {30'd0, e.q});
            chk("is_bpsk", {31'd0, is_bpsk}, {31'd0, e.isb});
            chk("sym_last", {31'd0, sym_last}, {31'd0, e.last});
            if (e.isb) chk("sym_bpsk", {31'd0, sym_bpsk}, {31'd0, e.q[1]});
          end
          if (gap_check && last_seen) begin
            chk("gap_invalid_edges", inv_run, 2);
            gaps_checked++;
          end
          last_seen = sym_last;
          inv_run   = 0;
        end else begin
          inv_run++;
        end
        if (underrun) urun_cnt++;
      end else begin
        chk("hold_between_enables", {26'd0, sym_valid, sym_bpsk, sym_qpsk, is_bpsk, sym_last}, {26'd0, prev});
        chk("underrun_off_strobe", {31'd0, underrun}, 32'd0);
      end
    end
    prev = {sym_valid, sym_bpsk, sym_qpsk, is_bpsk, sym_last};
  end

  // Expected frame: TRN ones (top bits of seed 7F), header, payload bits
  // taken left-justified from pld.
  task automatic push_frame(input logic [7:0] mcs, input logic [15:0] len,
                            input logic [7:0] sig, input logic [31:0] pld);
    logic [63:0] hdr;
    int   nsym;
    sym_t s;
    logic b;
    hdr  = {mcs, len, sig, 32'h0};
    nsym = mcs[5] ? int'(len) : int'(len >> 1);
    for (int i = 0; i < TRN; i++) begin
      s.q = 2'b11; s.isb = 1'b1; s.last = 1'b0;
      exp_q.push_back(s);
    end
    for (int i = 0; i < 64; i++) begin
      b = hdr[63-i];
      s.q = {b, b}; s.isb = 1'b1; s.last = (i == 63) && (nsym == 0);
      exp_q.push_back(s);
    end
    for (int i = 0; i < nsym; i++) begin
      if (mcs[5]) begin
        b = pld[31-i];
        s.q = {b, b}; s.isb = 1'b1;
      end else begin
        s.q = {pld[31-2*i], pld[30-2*i]}; s.isb = 1'b0;
      end
      s.last = (i == nsym - 1);
      exp_q.push_back(s);
    end
  endtask

  task automatic do_start(input logic [7:0] mcs, input logic [15:0] len, input logic [7:0] sig);
    @(negedge clk);
    cfg_mcs = mcs; cfg_len = len; cfg_sig = sig; start = 1'b1;
    do @(posedge clk); while (!clk_enable);
    #1 chk("busy_after_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_symbols_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_frame(input string name);
    wait_empty(name, 4000);
    repeat (12) @(negedge clk);
    chk({name, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
    chk("rst_sym_bpsk", {31'd0, sym_bpsk}, 32'd0);
    chk("rst_sym_qpsk", {30'd0, sym_qpsk}, 32'd0);
    chk("rst_sym_last", {31'd0, sym_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_is_bpsk", {31'd0, is_bpsk}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // BPSK, 16 bits from A5 3C, source always valid with spare bytes.
    src_q = '{8'hA5, 8'h3C, 8'hFF, 8'hFF}; src_en = 1; acc_cnt = 0; urun_cnt = 0;
    push_frame(8'h20, 16'd16, 8'h5A, 32'hA53C_0000);
    do_start(8'h20, 16'd16, 8'h5A);
    wait_frame("bpsk");
    chk("bpsk_bytes_accepted", acc_cnt, 2);
    chk("bpsk_underruns", urun_cnt, 0);
    src_en = 0; src_q.delete();

    // QPSK, 9 bits: D2 -> 11,01,00,10; ninth bit dropped, one byte only.
    @(negedge clk);
    src_q = '{8'hD2, 8'h80}; src_en = 1; acc_cnt = 0; urun_cnt = 0;
    push_frame(8'h00, 16'd9, 8'hC3, 32'hD200_0000);
    do_start(8'h00, 16'd9, 8'hC3);
    wait_frame("qpsk");
    chk("qpsk_bytes_accepted", acc_cnt, 1);
    src_en = 0; src_q.delete();

    // Header-only frame: s_tready must never rise.
    @(negedge clk);
    src_q = '{8'h11, 8'h22}; src_en = 1; acc_cnt = 0; rdy_seen = 0;
    push_frame(8'h20, 16'd0, 8'h7E, 32'h0);
    do_start(8'h20, 16'd0, 8'h7E);
    wait_frame("hdr_only");
    chk("hdr_only_tready_seen", rdy_seen, 0);
    chk("hdr_only_bytes_accepted", acc_cnt, 0);
    src_en = 0; src_q.delete();

    // No data during payload: 8 zero symbols, single underrun pulse.
    @(negedge clk);
    acc_cnt = 0; urun_cnt = 0;
    push_frame(8'h20, 16'd8, 8'h44, 32'h0);
    do_start(8'h20, 16'd8, 8'h44);
    wait_frame("underrun");
    chk("underrun_pulses", urun_cnt, 1);
    chk("underrun_bytes_accepted", acc_cnt, 0);

    // Strobe 1 in 4, start held high: two back-to-back header-only frames.
    @(negedge clk);
    div4 = 1; gap_check = 1; last_seen = 0; gaps_checked = 0;
    push_frame(8'h20, 16'd0, 8'h99, 32'h0);
    push_frame(8'h20, 16'd0, 8'h99, 32'h0);
    cfg_mcs = 8'h20; cfg_len = 16'd0; cfg_sig = 8'h99; start = 1'b1;
    wait_empty("b2b", 4000);
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("b2b_gaps_checked", gaps_checked, 1);
    chk("b2b_busy_end", {31'd0, busy}, 32'd0);
    div4 = 0; gap_check = 0;

    // Reset during payload, then a clean frame.
    @(negedge clk);
    src_q = '{8'hA5, 8'h3C}; src_en = 1;
    push_frame(8'h20, 16'd16, 8'h5A, 32'hA53C_0000);
    do_start(8'h20, 16'd16, 8'h5A);
    begin
      int n = 0;
      while (exp_q.size() > 8 && n < 4000) begin
        @(negedge clk);
        n++;
      end
      chk("midpld_reached", {31'd0, (exp_q.size() <= 8)}, 32'd1);
    end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_sym_valid", {31'd0, sym_valid}, 32'd0);
    chk("midrst_sym_qpsk", {30'd0, sym_qpsk}, 32'd0);
    chk("midrst_sym_last", {31'd0, sym_last}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("midrst_is_bpsk", {31'd0, is_bpsk}, 32'd1);
    rst = 1'b0;
    src_en = 0; src_q.delete();
    @(negedge clk);
    src_q = '{8'hA5, 8'h3C}; src_en = 1; acc_cnt = 0; urun_cnt = 0;
    push_frame(8'h20, 16'd16, 8'h5A, 32'hA53C_0000);
    do_start(8'h20, 16'd16, 8'h5A);
    wait_frame("post_rst");
    chk("post_rst_bytes_accepted", acc_cnt, 2);
    chk("post_rst_underruns", urun_cnt, 0);
    src_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
